mdp_result_streamer: RTL
========================

MDP_RESULT_STREAMER -- requirements
Module: mdp_result_streamer

Interface
REQ-001 Parameter MAX_CELLS, default 32: maximum number of grid cells held in a snapshot.
REQ-002 Parameter UTIL_W, default 16: utility word width (fixed-point, as produced by MD_state_machine).
REQ-003 Port clk, input, 1: single system clock; all state updates on the rising edge.
REQ-004 Port Reset, input, 1: reset is synchronous and active-high (Already decided).
REQ-005 Port mdp_done, input, 1: MDP_done from MD_state_machine; results valid while high.
REQ-006 Port cur_util, input, MAX_CELLS*UTIL_W (512): packed utilities; cell i at bits [i*16 +: 16].
REQ-007 Port policy, input, 2*MAX_CELLS (64): packed policy codes; cell i at bits [i*2 +: 2].
REQ-008 Port in_world, input, 2*MAX_CELLS (64): packed cell types; cell i at bits [i*2 +: 2].
REQ-009 Port in_width and in_depth, input, 8 each: grid dimensions.
REQ-010 Port ack, output, 1: acknowledge to MD_state_machine ack input.
REQ-011 Port out_valid, output, 1, and out_ready, input, 1: downstream valid/ready handshake.
REQ-012 Port out_index, output, 5: cell index of the current beat.
REQ-013 Port out_util, output, 16, and out_policy, output, 2: current beat payload.
REQ-014 Port out_last, output, 1: high on the final beat of a result set.
REQ-015 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, STREAM, ACK; one-hot encoding.
REQ-017 IDLE, mdp_done=1 at an edge: load cur_util, policy, and in_world into snapshot registers, and load n_cells = min(in_width*in_depth, 32), using a 16-bit product before the clamp.
REQ-018 Same edge: idx = first streamable cell; go to STREAM, or go to ACK if no cell is streamable (n_cells = 0).
REQ-019 STREAM: out_valid=1; out_index=idx; out_util and out_policy come from the snapshot, never from live inputs.
REQ-020 A beat transfers on an edge with out_valid and out_ready both high; the payload SHALL stay stable until that transfer.
REQ-021 After a transfer, idx advances to the next streamable cell below n_cells (one beat per cycle max, zero bubbles); out_last=1 when no further streamable cell exists.
REQ-022 Transfer with out_last=1: go to ACK, with out_valid=0 from the next cycle.
REQ-023 ACK: ack=1, held while mdp_done=1; on the first edge with mdp_done=0, go to IDLE, with ack=0 the following cycle.
REQ-024 mdp_done changes during STREAM are ignored; the snapshot is immutable until IDLE.
REQ-025 Without the Configuration feature, streamable means index < n_cells.

Reset
REQ-026 Reset=1 at any edge, including mid-STREAM or mid-ACK: state=IDLE, idx=0.
REQ-027 Reset values: ack, out_valid, out_last, and busy = 0; out_index, out_util, and out_policy = 0.
REQ-028 Reset has priority over every other event at the same edge; no partial beat is reported after reset.

Configuration
REQ-029 Macro MDP_SKIP_WALL_EN: when defined, a cell whose snapshot type is 2'b11 (wall) is not streamable and is skipped with no bubble cycle.
REQ-030 When MDP_SKIP_WALL_EN is undefined, wall cells stream like any other cell, and in_world is captured but unused.

Structure
REQ-031 Shared package mdp_pkg holds MAX_CELLS, UTIL_W, and the location-type constants LOC_EMPTY=00, LOC_POS=01, LOC_NEG=10, LOC_WALL=11.
REQ-032 mdp_pkg also holds the policy-code constants and the FSM state typedef, shared with MD_state_machine.
REQ-033 One sub-module, mdp_next_cell: combinational priority search returning the next streamable index above a given index, plus a none-found flag.

Verification
REQ-034 4x3 grid, no walls, out_ready held 1, mdp_done pulses then holds: 12 beats (idx 0..11) on consecutive cycles; out_last on idx 11; ack next cycle.
REQ-035 Same grid, out_ready toggling 1/0 each cycle: payload stable while stalled; 12 beats in 23 cycles; utilities match the snapshot.
REQ-036 MDP_SKIP_WALL_EN defined, world cells 5 and 7 = 2'b11: 10 beats; indices 5 and 7 absent; out_last on 11.
REQ-037 in_width=0: no beats; ack=1 one cycle after capture; mdp_done low -> IDLE, ack=0.
REQ-038 in_width=8, in_depth=8 (64): clamped to 32 beats, last index 31.
REQ-039 Reset asserted during beat 4, and cur_util changed during STREAM: all outputs 0 next cycle; a fresh mdp_done restarts from idx 0 with the new values.

Source files
------------

// File: rtl/mdp_pkg.sv
// Types and constants shared by the MDP solver blocks: grid sizing, location
// and policy codes, and the result streamer FSM states.
package mdp_pkg;

  localparam int MAX_CELLS = 32;
  localparam int UTIL_W    = 16;

  localparam logic [1:0] LOC_EMPTY = 2'b00;
  localparam logic [1:0] LOC_POS   = 2'b01;
  localparam logic [1:0] LOC_NEG   = 2'b10;
  localparam logic [1:0] LOC_WALL  = 2'b11;

  localparam logic [1:0] POL_UP    = 2'b00;
  localparam logic [1:0] POL_RIGHT = 2'b01;
  localparam logic [1:0] POL_DOWN  = 2'b10;
  localparam logic [1:0] POL_LEFT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_STREAM = 3'b010,
    ST_ACK    = 3'b100
  } stream_state_t;

endpackage

// File: rtl/mdp_next_cell.sv
// Priority search for the lowest streamable cell index >= base and < n_cells.
// With MDP_SKIP_WALL_EN defined, wall cells are never streamable.
module mdp_next_cell #(
  parameter int N  = mdp_pkg::MAX_CELLS,
  parameter int IW = $clog2(N)
) (
  input  logic [IW:0]    base,
  input  logic [IW:0]    n_cells,
  input  logic [2*N-1:0] world,
  output logic [IW-1:0]  next_idx,
  output logic           none
);
  import mdp_pkg::*;

  logic [N-1:0] hit;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      hit[i] = ((IW+1)'(i) >= base) && ((IW+1)'(i) < n_cells);
`ifdef MDP_SKIP_WALL_EN
      if (world[2*i +: 2] == LOC_WALL) hit[i] = 1'b0;
`endif
    end
  end

`ifndef MDP_SKIP_WALL_EN
  logic unused_world;
  assign unused_world = ^world;
`endif

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    none     = 1'b1;
    next_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        none     = 1'b0;
        next_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mdp_result_streamer.sv
// Snapshots MD_state_machine results on mdp_done and streams one cell per beat,
// then acknowledges. Optional macro MDP_SKIP_WALL_EN drops wall cells from the stream.
module mdp_result_streamer #(
  parameter int MAX_CELLS = mdp_pkg::MAX_CELLS,
  parameter int UTIL_W    = mdp_pkg::UTIL_W
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic                          mdp_done,
  input  logic [MAX_CELLS*UTIL_W-1:0]   cur_util,
  input  logic [2*MAX_CELLS-1:0]        policy,
  input  logic [2*MAX_CELLS-1:0]        in_world,
  input  logic [7:0]                    in_width,
  input  logic [7:0]                    in_depth,
  output logic                          ack,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(MAX_CELLS)-1:0]  out_index,
  output logic [UTIL_W-1:0]             out_util,
  output logic [1:0]                    out_policy,
  output logic                          out_last,
  output logic                          busy,
  output mdp_pkg::stream_state_t        dbg_state
);
  import mdp_pkg::*;

  localparam int IW = $clog2(MAX_CELLS);

  // Handshake: a beat moves on a rising edge where out_valid and out_ready are
  // both high; until then index, payload and out_last hold steady. out_valid
  // never drops without a transfer except on Reset.

  stream_state_t                 state;
  logic [IW-1:0]                 idx;
  logic [IW:0]                   n_cells;
  logic [MAX_CELLS*UTIL_W-1:0]   snap_util;
  logic [2*MAX_CELLS-1:0]        snap_pol;
  logic [2*MAX_CELLS-1:0]        snap_world;

  logic [15:0]   area;
  logic [IW:0]   area_clamped;
  logic [IW:0]   after_idx;
  logic [IW-1:0] first_idx, next_idx;
  logic          first_none, next_none;

  assign area         = {8'd0, in_width} * {8'd0, in_depth};
  assign area_clamped = (area > 16'(MAX_CELLS)) ? (IW+1)'(MAX_CELLS) : area[IW:0];
  assign after_idx    = {1'b0, idx} + (IW+1)'(1);

  // First cell is searched on live inputs so the capture edge can start streaming.
  mdp_next_cell #(.N(MAX_CELLS), .IW(IW)) u_first (
    .base     ('0),
    .n_cells  (area_clamped),
    .world    (in_world),
    .next_idx (first_idx),
    .none     (first_none)
  );

  mdp_next_cell #(.N(MAX_CELLS), .IW(IW)) u_next (
    .base     (after_idx),
    .n_cells  (n_cells),
    .world    (snap_world),
    .next_idx (next_idx),
    .none     (next_none)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      n_cells    <= '0;
      snap_util  <= '0;
      snap_pol   <= '0;
      snap_world <= '0;
      out_valid  <= 1'b0;
      ack        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mdp_done) begin
            snap_util  <= cur_util;
            snap_pol   <= policy;
            snap_world <= in_world;
            n_cells    <= area_clamped;
            idx        <= first_idx;
            if (first_none) begin
              state <= ST_ACK;
              ack   <= 1'b1;
            end else begin
              state     <= ST_STREAM;
              out_valid <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (next_none) begin
              state     <= ST_ACK;
              out_valid <= 1'b0;
              ack       <= 1'b1;
            end else begin
              idx <= next_idx;
            end
          end
        end
        ST_ACK: begin
          if (!mdp_done) begin
            state <= ST_IDLE;
            ack   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          ack       <= 1'b0;
        end
      endcase
    end
  end

  assign out_last   = out_valid & next_none;
  assign out_index  = out_valid ? idx : '0;
  assign out_util   = out_valid ? snap_util[idx*UTIL_W +: UTIL_W] : '0;
  assign out_policy = out_valid ? snap_pol[idx*2 +: 2] : 2'b00;
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;

endmodule
